// File: rtl/add_result_buffer.sv
// Result buffer behind the 4-bit adder: captures {cout, s} into a FWFT FIFO
// and keeps a saturating count of accepted results that carried out.
module add_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         s,
  input  logic                     cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH:0]           out_sum,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         carry_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] carry_q, carry_d;
  logic             push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_sum   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign carry_count = carry_q;

  // A full buffer refuses pushes even when a pop frees a slot this cycle.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    carry_d  = carry_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      carry_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && cout && (carry_q != {CNT_W{1'b1}}))
        carry_d = carry_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      carry_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      if (push && !clr) mem_q[wr_ptr_q] <= {cout, s};
    end
  end
endmodule

// File: tb/tb_add_result_buffer.sv
// Directed table-driven bench for add_result_buffer, plus hand sequences for
// carry saturation and asynchronous reset.
module tb_add_result_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0, cout = 1'b0;
  logic [3:0] s = 4'h0;
  logic       in_ready, out_valid, full, empty;
  logic [4:0] out_sum;
  logic [2:0] count;
  logic [7:0] carry_count;

  logic       iv1 = 1'b0, or1 = 1'b0, c1 = 1'b0;
  logic [3:0] s1 = 4'h0;
  logic       ir1, ov1, full1, empty1;
  logic [4:0] sum1;
  logic [2:0] cnt1;
  logic [1:0] cc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_result_buffer #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .count(count), .full(full), .empty(empty),
    .carry_count(carry_count));

  add_result_buffer #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .clr(1'b0), .in_valid(iv1), .in_ready(ir1),
    .s(s1), .cout(c1), .out_valid(ov1), .out_ready(or1),
    .out_sum(sum1), .count(cnt1), .full(full1), .empty(empty1),
    .carry_count(cc1));

  typedef struct {
    logic       iv;
    logic [3:0] s;
    logic       c;
    logic       ordy;
    logic       clr;
    logic       e_ov;
    logic [4:0] e_sum;
    logic [2:0] e_cnt;
    logic [7:0] e_cc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int iv, int sv, int c, int o, int cl,
                              int eov, int es, int ec, int ecc);
    vec_t v;
    v.iv = 1'(iv); v.s = 4'(sv); v.c = 1'(c); v.ordy = 1'(o); v.clr = 1'(cl);
    v.e_ov = 1'(eov); v.e_sum = 5'(es); v.e_cnt = 3'(ec); v.e_cc = 8'(ecc);
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_state(string tag);
    chk({tag, ".ov"},   int'(out_valid),   0);
    chk({tag, ".emp"},  int'(empty),       1);
    chk({tag, ".full"}, int'(full),        0);
    chk({tag, ".ir"},   int'(in_ready),    1);
    chk({tag, ".cnt"},  int'(count),       0);
    chk({tag, ".cc"},   int'(carry_count), 0);
  endtask

  initial begin
    // Scenario 1: single push, hold, pop
    tbl.push_back(mk(1, 'ha, 0, 0, 0, 1, 'b01010, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'b01010, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Scenario 2: fill, refused pushes (incl. while popping), drain in order
    tbl.push_back(mk(1, 'h1, 0, 0, 0, 1, 'h01, 1, 0));
    tbl.push_back(mk(1, 'h0, 1, 0, 0, 1, 'h01, 2, 1));
    tbl.push_back(mk(1, 'h4, 0, 0, 0, 1, 'h01, 3, 1));
    tbl.push_back(mk(1, 'he, 0, 0, 0, 1, 'h01, 4, 1));
    tbl.push_back(mk(1, 'h3, 0, 0, 0, 1, 'h01, 4, 1));
    tbl.push_back(mk(1, 'h3, 1, 1, 0, 1, 'h10, 3, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 'h04, 2, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 'h0e, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Scenario 3: streaming push+pop, pointers wrap
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, i + 3, 0, 1, 0, 1, i + 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Scenario 5: clr beats a concurrent push+pop
    tbl.push_back(mk(1, 'h5, 1, 0, 0, 1, 'h15, 1, 2));
    tbl.push_back(mk(1, 'h6, 0, 0, 0, 1, 'h15, 2, 2));
    tbl.push_back(mk(1, 'h7, 0, 0, 0, 1, 'h15, 3, 2));
    tbl.push_back(mk(1, 'h8, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Scenario 4: carry-out results
    tbl.push_back(mk(1, 'h0, 1, 0, 0, 1, 'h10, 1, 1));
    tbl.push_back(mk(1, 'h1, 1, 0, 0, 1, 'h10, 2, 2));

    #2;
    chk_idle_state("rst0");
    chk("rst0.sum", int'(out_sum), 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturating carry counter on the narrow instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv1 = 1'b1; c1 = 1'b1; or1 = 1'b1; s1 = 4'(i);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.cc", i), int'(cc1), (i < 3) ? i + 1 : 3);
      chk($sformatf("sat%0d.cnt", i), int'(cnt1), 1);
    end
    @(negedge clk);
    iv1 = 1'b0; or1 = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      in_valid = tbl[k].iv; s = tbl[k].s; cout = tbl[k].c;
      out_ready = tbl[k].ordy; clr = tbl[k].clr;
      @(posedge clk); #1;
      chk($sformatf("r%0d.ov", k),   int'(out_valid), int'(tbl[k].e_ov));
      chk($sformatf("r%0d.cnt", k),  int'(count),     int'(tbl[k].e_cnt));
      chk($sformatf("r%0d.full", k), int'(full),      int'(tbl[k].e_cnt == 3'd4));
      chk($sformatf("r%0d.emp", k),  int'(empty),     int'(tbl[k].e_cnt == 3'd0));
      chk($sformatf("r%0d.ir", k),   int'(in_ready),  int'(tbl[k].e_cnt != 3'd4));
      chk($sformatf("r%0d.cc", k),   int'(carry_count), int'(tbl[k].e_cc));
      if (tbl[k].e_ov)
        chk($sformatf("r%0d.sum", k), int'(out_sum), int'(tbl[k].e_sum));
    end

    // Scenario 6: asynchronous reset mid-cycle with two entries held
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    @(posedge clk); #2;
    chk("arst.pre_ov", int'(out_valid), 1);
    chk("arst.pre_cnt", int'(count), 2);
    rst = 1'b1;
    #1;
    chk_idle_state("arst");
    chk("arst.sum", int'(out_sum), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle_state("post");
    @(negedge clk);
    in_valid = 1'b1; s = 4'ha; cout = 1'b0;
    @(posedge clk); #1;
    chk("post1.ov",  int'(out_valid), 1);
    chk("post1.sum", int'(out_sum), 'b01010);
    chk("post1.cnt", int'(count), 1);
    @(negedge clk);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_result_buffer.md
Name: add_result_buffer

Overview:
Downstream stage of the 4-bit adder. Captures each adder result {cout, s} through a valid/ready handshake into a small first-word-fall-through FIFO, which decouples the adder from a slower consumer. Also keeps a saturating count of results that carried out, for debug and observation in the bench.

Parameters:
WIDTH, 4, adder operand/sum width; stored entry is WIDTH+1 bits {cout, s}
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, 8, width of carry_count

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush of FIFO and carry_count
in_valid  input  1  adder result present on s/cout
in_ready  output  1  buffer can accept; equals !full
s  input  WIDTH  adder sum
cout  input  1  adder carry out
out_valid  output  1  head entry valid; equals !empty
out_ready  input  1  consumer accepts head entry
out_sum  output  WIDTH+1  head entry {cout, s}
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
carry_count  output  CNT_W  accepted entries with cout=1, saturating

Behaviour:
- Reset (rst=1, asynchronous, immediate):
  - rd/wr pointers = 0, count = 0, all storage = 0, carry_count = 0.
  - Outputs during and after reset: empty=1, full=0, out_valid=0, in_ready=1, out_sum=0.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the rising edge of clk.
- Push: writes {cout, s} to mem[wr_ptr] and advances wr_ptr modulo DEPTH.
- Pop: advances rd_ptr modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on push+pop or no transfer.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. full/empty are derived from count, never from pointer compare.
- FWFT read:
  - out_sum = mem[rd_ptr], combinational from registered storage.
  - An entry pushed into an empty buffer at edge N appears on out_sum with out_valid=1 after edge N, so latency is 1 cycle.
  - out_sum holds stable while out_valid=1 and out_ready=0.
- in_ready = !full. When full, a push is refused even if a pop occurs in the same cycle, so there is no full-pass-through. An upstream source holding in_valid waits one cycle.
- When empty, out_ready is ignored and count never underflows. out_sum shows stale mem[rd_ptr] and is don't-care while out_valid=0.
- Simultaneous push+pop, non-empty and non-full: both happen, count unchanged, and ordering is preserved.
- carry_count:
  - +1 on each accepted push with cout=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Refused pushes (full) are not counted.
- clr=1 at an edge:
  - pointers, count and carry_count go to 0; storage contents are not required to clear.
  - Takes priority over any push/pop in the same cycle; that transfer is dropped.
- rst mid-operation: all in-flight entries are discarded and the state becomes identical to power-on reset.
- Width arithmetic: no arithmetic on data. Entries are stored and returned bit-exact with cout as the MSB.

Test Plan:
1. Reset then single push, s=1010 cout=0, out_ready=0 -> next cycle out_valid=1, out_sum=01010, count=1, carry_count=0; out_sum holds for 3 idle cycles.
2. Push 4 entries 0001/0, 0000/1, 0100/0, 1110/0 with out_ready=0 -> full=1, in_ready=0. A 5th push of 0011/0 is refused, count=4. Draining with out_ready=1 yields 00001, 10000, 00100, 01110 in that order, then empty=1.
3. Continuous push+pop for 10 cycles, pointers wrapping 2.5 times, with in_valid and out_ready both held 1 -> count stays at 1 after the first cycle and every value emerges exactly 1 cycle after entry.
4. Carries: push s=0000 cout=1 (1111+0001) and s=0001 cout=1 (1111+0010) -> carry_count=2. With CNT_W=2, 5 carry pushes -> carry_count=3 (saturated).
5. Assert clr while count=3 and push+pop are also active -> next cycle count=0, empty=1, carry_count=0, in_ready=1, and neither transfer takes effect.
6. Assert rst asynchronously mid-cycle with count=2 -> out_valid drops immediately, before the next clk edge, and the post-reset state matches scenario 1's initial state.
